// File: rtl/pc_stack.sv
// Program counter with a bounded return-address stack and sticky fault flags.
// One action per cycle by fixed priority: reset > ret > call > load > inc > hold.
module pc_stack #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8,
  localparam int SPW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in,
  input  logic             load,
  input  logic             inc,
  input  logic             call,
  input  logic             ret,
  output logic [WIDTH-1:0] out,
  output logic [SPW-1:0]   sp,
  output logic             full,
  output logic             empty,
  output logic             overflow,
  output logic             underflow
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] stack [DEPTH];
  logic [SPW-1:0]   sp_dec;
  logic [AW-1:0]    push_idx;
  logic [AW-1:0]    pop_idx;
  logic [WIDTH-1:0] out_inc;
  logic             do_push;

  assign full     = (sp == SPW'(DEPTH));
  assign empty    = (sp == '0);
  assign sp_dec   = sp - SPW'(1);
  assign push_idx = sp[AW-1:0];
  assign pop_idx  = sp_dec[AW-1:0];
  assign out_inc  = out + WIDTH'(1);
  assign do_push  = !reset && !ret && call && !full;

  always_ff @(posedge clk) begin
    if (reset) begin
      out       <= '0;
      sp        <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (ret) begin
      if (empty) begin
        underflow <= 1'b1;
      end else begin
        out <= stack[pop_idx];
        sp  <= sp_dec;
      end
    end else if (call) begin
      // A call while full is refused outright: no jump, no push.
      if (full) begin
        overflow <= 1'b1;
      end else begin
        out <= in;
        sp  <= sp + SPW'(1);
      end
    end else if (load) begin
      out <= in;
    end else if (inc) begin
      out <= out_inc;
    end
  end

  // Stack storage is never reset; occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    if (do_push) begin
      stack[push_idx] <= out_inc;
    end
  end

endmodule

// File: tb/tb_pc_stack.sv
// Randomized and directed bench for pc_stack against a queue-based reference model.
module tb_pc_stack;

  localparam int W    = 12;
  localparam int D    = 3;
  localparam int SPW  = $clog2(D + 1);
  localparam int MASK = (1 << W) - 1;

  logic           clk;
  logic           reset;
  logic [W-1:0]   in;
  logic           load, inc, call, ret;
  logic [W-1:0]   out;
  logic [SPW-1:0] sp;
  logic           full, empty, overflow, underflow;

  int tests;
  int fails;

  // Reference model: a plain queue as the LIFO
  int m_out;
  int m_q[$];
  bit m_ovf;
  bit m_udf;

  pc_stack #(.WIDTH(W), .DEPTH(D)) dut (
    .clk(clk), .reset(reset), .in(in), .load(load), .inc(inc),
    .call(call), .ret(ret), .out(out), .sp(sp), .full(full),
    .empty(empty), .overflow(overflow), .underflow(underflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step(input bit r, input bit rt, input bit c, input bit l,
                            input bit i, input int din);
    if (r) begin
      m_out = 0;
      m_q.delete();
      m_ovf = 0;
      m_udf = 0;
    end else if (rt) begin
      if (m_q.size() == 0) m_udf = 1;
      else m_out = m_q.pop_back();
    end else if (c) begin
      if (m_q.size() == D) m_ovf = 1;
      else begin
        m_q.push_back((m_out + 1) & MASK);
        m_out = din & MASK;
      end
    end else if (l) begin
      m_out = din & MASK;
    end else if (i) begin
      m_out = (m_out + 1) & MASK;
    end
  endtask

  task automatic cycle(input bit r, input bit rt, input bit c, input bit l,
                       input bit i, input int din);
    reset = r; ret = rt; call = c; load = l; inc = i; in = W'(din);
    @(posedge clk);
    model_step(r, rt, c, l, i, din);
    #1;
    chk("out", 32'(out), 32'(m_out));
    chk("sp", 32'(sp), 32'(m_q.size()));
    chk("full", 32'(full), 32'(m_q.size() == D));
    chk("empty", 32'(empty), 32'(m_q.size() == 0));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("underflow", 32'(underflow), 32'(m_udf));
    reset = 0; ret = 0; call = 0; load = 0; inc = 0;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    m_out = 0;
    m_ovf = 0;
    m_udf = 0;
    reset = 0; ret = 0; call = 0; load = 0; inc = 0; in = '0;
    @(negedge clk);

    // Reset, counting, and wrap at the top of the address space
    cycle(1, 0, 0, 0, 0, 0);
    chk("rst_out", 32'(out), 0);
    chk("rst_empty", 32'(empty), 1);
    for (int k = 0; k < 17; k++) cycle(0, 0, 0, 0, 1, 0);
    chk("inc17", 32'(out), 17);
    cycle(0, 0, 0, 1, 0, 'hFF8);
    for (int k = 0; k < 9; k++) cycle(0, 0, 0, 0, 1, 0);
    chk("inc_wrap", 32'(out), 1);

    // Call / return
    cycle(0, 0, 0, 1, 0, 5);
    cycle(0, 0, 1, 0, 0, 'h100);
    chk("call_out", 32'(out), 'h100);
    chk("call_sp", 32'(sp), 1);
    cycle(0, 0, 0, 0, 1, 0);
    cycle(0, 0, 0, 0, 1, 0);
    chk("inc2", 32'(out), 'h102);
    cycle(0, 1, 0, 0, 0, 0);
    chk("ret_out", 32'(out), 6);
    chk("ret_sp", 32'(sp), 0);

    // Overflow then drain to underflow
    cycle(1, 0, 0, 0, 0, 0);
    cycle(0, 0, 1, 0, 0, 'h10);
    cycle(0, 0, 1, 0, 0, 'h20);
    cycle(0, 0, 1, 0, 0, 'h30);
    cycle(0, 0, 1, 0, 0, 'h40);
    chk("ovf_out", 32'(out), 'h30);
    chk("ovf_flag", 32'(overflow), 1);
    chk("ovf_full", 32'(full), 1);
    cycle(0, 1, 0, 0, 0, 0);
    chk("pop1", 32'(out), 'h21);
    cycle(0, 1, 0, 0, 0, 0);
    chk("pop2", 32'(out), 'h11);
    cycle(0, 1, 0, 0, 0, 0);
    chk("pop3", 32'(out), 1);
    cycle(0, 1, 0, 0, 0, 0);
    chk("udf_flag", 32'(underflow), 1);
    chk("udf_hold", 32'(out), 1);

    // Priority
    cycle(0, 0, 1, 1, 1, 'h40);
    chk("prio_call", 32'(out), 'h40);
    chk("prio_call_sp", 32'(sp), 1);
    cycle(0, 1, 1, 0, 0, 'h77);
    chk("prio_ret_sp", 32'(sp), 0);
    cycle(0, 0, 0, 1, 1, 7);
    chk("prio_load", 32'(out), 7);

    // Reset mid-operation with call asserted
    cycle(0, 0, 1, 0, 0, 'h1);
    cycle(0, 0, 1, 0, 0, 'h2);
    cycle(0, 0, 1, 0, 0, 'h3);
    cycle(0, 0, 1, 0, 0, 'h4);
    chk("pre_rst_ovf", 32'(overflow), 1);
    cycle(1, 0, 1, 0, 0, 'h55);
    chk("rst_mid_out", 32'(out), 0);
    chk("rst_mid_sp", 32'(sp), 0);
    chk("rst_mid_ovf", 32'(overflow), 0);
    cycle(0, 1, 0, 0, 0, 0);
    chk("rst_mid_udf", 32'(underflow), 1);

    // Return address wraps modulo 2^W
    cycle(0, 0, 0, 1, 0, MASK);
    cycle(0, 0, 1, 0, 0, 'h10);
    cycle(0, 1, 0, 0, 0, 0);
    chk("push_wrap", 32'(out), 0);

    // Randomized traffic
    for (int k = 0; k < 3000; k++) begin
      cycle($urandom_range(0, 63) == 0, $urandom_range(0, 3) == 0,
            $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0,
            $urandom_range(0, 1) == 0, int'($urandom & MASK));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
